// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared constants for the pipelined carry-lookahead adder:
//               default geometry and the add/subtract operation encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int   ADD_WIDTH  = 32;
    localparam int   ADD_GROUP  = 4;
    localparam int   ADD_STAGES = 2;

    localparam logic OP_ADD     = 1'b0;
    localparam logic OP_SUB     = 1'b1;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_cla_pipe_cla_group.sv
`default_nettype none
// ============================================================================
// Module      : cla_group
// Description : GROUP-bit carry-lookahead block. All internal carries are
//               formed in parallel from bit generate/propagate terms; also
//               exports the group propagate/generate pair.
// Revision    : 1.0 - initial release
// ============================================================================
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             pg,
    output logic             gg,
    output logic             cout
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;      // c[i] is the carry into bit i
    logic             gacc;
    logic             pchain;

    assign p = a ^ b;
    assign g = a & b;

    // Sum-of-products expansion of every carry; the final iteration leaves the group G/P terms.
    always_comb begin
        c      = '0;
        gacc   = 1'b0;
        pchain = 1'b1;
        c[0]   = cin;
        for (int i = 0; i < GROUP; i++) begin
            gacc   = 1'b0;
            pchain = 1'b1;
            for (int j = i; j >= 0; j--) begin
                gacc   = gacc | (g[j] & pchain);
                pchain = pchain & p[j];
            end
            c[i+1] = gacc | (pchain & cin);
        end
    end

    assign gg   = gacc;
    assign pg   = pchain;
    assign cout = gg | (pg & cin);
    assign sum  = p ^ c[GROUP-1:0];

endmodule : cla_group
`default_nettype wire

// File: rtl/adder_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module      : adder_cla_pipe
// Description : Pipelined carry-lookahead adder/subtractor. The word is split
//               into STAGES segments, one per register stage, each built from
//               rippled GROUP-bit lookahead groups. Valid/ready elastic
//               handshake with full backpressure; sum, carry-out, signed
//               overflow and zero flags are driven straight from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_cla_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = ADD_WIDTH,
    parameter int GROUP  = ADD_GROUP,
    parameter int STAGES = ADD_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] S_o,
    output logic             Cout_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / GROUP;

    if (!(GROUP == 2 || GROUP == 4 || GROUP == 8)) begin : g_chk_group
        $error("adder_cla_pipe: GROUP must be 2, 4 or 8");
    end
    if ((WIDTH % (GROUP * STAGES)) != 0) begin : g_chk_width
        $error("adder_cla_pipe: WIDTH must be a multiple of GROUP*STAGES");
    end
    if (STAGES < 1 || STAGES > WIDTH / GROUP) begin : g_chk_stages
        $error("adder_cla_pipe: STAGES must lie in 1..WIDTH/GROUP");
    end

    // Per-stage inputs: index 0 is the accepted beat, index k>0 is stage k-1's register.
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] v_stage;
    logic [STAGES-1:0] ready;
    logic              is_sub;
    logic              rdy_acc;

    assign is_sub  = (sub_i == OP_SUB);
    assign a_in[0] = A_i;
    assign b_in[0] = B_i ^ {WIDTH{is_sub}};
    assign s_in[0] = '0;
    assign c_in[0] = is_sub ? 1'b1 : Cin_i;
    assign v_in[0] = in_valid_i;

    // Ready chain from the output back to the input: a stage may load when empty or draining.
    always_comb begin
        ready   = '0;
        rdy_acc = out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy_acc  = !v_stage[k] | rdy_acc;
            ready[k] = rdy_acc;
        end
    end

    assign in_ready_o = ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;

        logic [NGRP:0]      gc;
        logic [SEG-1:0]     seg_sum;
        logic [NGRP-1:0]    grp_pg;
        logic [NGRP-1:0]    grp_gg;
        logic               load;
        logic               v_q;
        logic               v_d;
        logic [WIDTH-1:0]   s_q;
        logic [WIDTH-1:0]   s_d;
        logic               c_q;
        logic               c_d;

        assign gc[0] = c_in[k];
        assign load  = ready[k] & v_in[k];

        for (genvar i = 0; i < NGRP; i++) begin : g_grp
            cla_group #(
                .GROUP (GROUP)
            ) u_grp (
                .a    (a_in[k][LO + i*GROUP +: GROUP]),
                .b    (b_in[k][LO + i*GROUP +: GROUP]),
                .cin  (gc[i]),
                .sum  (seg_sum[i*GROUP +: GROUP]),
                .pg   (grp_pg[i]),
                .gg   (grp_gg[i]),
                .cout (gc[i+1])
            );
        end

        // Next state: hold on stall, otherwise merge this segment's sum into the partial word.
        always_comb begin
            v_d = ready[k] ? v_in[k] : v_q;
            s_d = s_q;
            c_d = c_q;
            if (load) begin
                s_d            = s_in[k];
                s_d[LO +: SEG] = seg_sum;
                c_d            = gc[NGRP];
            end
        end

        // Stage register: valid, accumulated sum and segment carry-out.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
            end else begin
                v_q <= v_d;
                s_q <= s_d;
                c_q <= c_d;
            end
        end

        assign v_stage[k] = v_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] a_d;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] b_d;

            // Operands not yet consumed travel alongside the partial sum.
            always_comb begin
                a_d = a_q;
                b_d = b_q;
                if (load) begin
                    a_d = a_in[k];
                    b_d = b_in[k];
                end
            end

            // Operand carry registers for the following segments.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    a_q <= '0;
                    b_q <= '0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end

            assign a_in[k+1] = a_q;
            assign b_in[k+1] = b_q;
            assign s_in[k+1] = s_q;
            assign c_in[k+1] = c_q;
            assign v_in[k+1] = v_q;
        end else begin : g_last
            logic cmsb;
            logic ovf_q;
            logic ovf_d;
            logic zero_q;
            logic zero_d;

            // Carry into the MSB recovered from the MSB sum bit and its operand bits.
            assign cmsb = seg_sum[SEG-1] ^ a_in[k][WIDTH-1] ^ b_in[k][WIDTH-1];

            // Flags for the completed word, captured together with the final sum.
            always_comb begin
                ovf_d  = ovf_q;
                zero_d = zero_q;
                if (load) begin
                    ovf_d  = cmsb ^ gc[NGRP];
                    zero_d = (s_d == '0);
                end
            end

            // Output flag registers.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end

            assign out_valid_o = v_q;
            assign S_o         = s_q;
            assign Cout_o      = c_q;
            assign ovf_o       = ovf_q;
            assign zero_o      = zero_q;
        end
    end

endmodule : adder_cla_pipe
`default_nettype wire

// File: tb/tb_adder_cla_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_cla_pipe
// Description : Self-checking bench for adder_cla_pipe: vector table,
//               latency, backpressure, mid-stream reset and random streaming
//               against an arithmetic reference through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_cla_pipe;
    import adder_pkg::*;

    localparam int W  = 32;
    localparam int G  = 4;
    localparam int ST = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] A_i;
    logic [W-1:0] B_i;
    logic         Cin_i;
    logic         sub_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] S_o;
    logic         Cout_o;
    logic         ovf_o;
    logic         zero_o;

    adder_cla_pipe #(
        .WIDTH  (W),
        .GROUP  (G),
        .STAGES (ST)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .A_i         (A_i),
        .B_i         (B_i),
        .Cin_i       (Cin_i),
        .sub_i       (sub_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .S_o         (S_o),
        .Cout_o      (Cout_o),
        .ovf_o       (ovf_o),
        .zero_o      (zero_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    bit   accepted;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] bp;
        logic         c;
        logic [W:0]   full;
        logic [W-1:0] low;
        bp     = sub ? ~b : b;
        c      = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, c};
        low    = {1'b0, a[W-2:0]} + {1'b0, bp[W-2:0]} + {{(W-1){1'b0}}, c};
        e.s    = full[W-1:0];
        e.cout = full[W];
        e.ovf  = low[W-1] ^ full[W];
        e.zero = (full[W-1:0] == '0);
        return e;
    endfunction

    function automatic vec_t mkv(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input logic [W-1:0] s,
                                 input logic cout, input logic ovf, input logic zero);
        vec_t v;
        v.a = a; v.b = b; v.cin = cin; v.sub = sub;
        v.s = s; v.cout = cout; v.ovf = ovf; v.zero = zero;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
        A_i = a; B_i = b; Cin_i = cin; sub_i = sub;
        in_valid_i = 1'b1;
        cur_exp = model(a, b, cin, sub);
    endtask

    // Called at the falling edge: scoreboard pop on output transfer, push on input transfer.
    task automatic sample();
        exp_t e;
        accepted = 1'b0;
        if (out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", {31'b0, out_valid_o}, '0);
            end else begin
                e = sb.pop_front();
                n_out++;
                check("sum",  S_o, e.s);
                check("cout", {31'b0, Cout_o}, {31'b0, e.cout});
                check("ovf",  {31'b0, ovf_o},  {31'b0, e.ovf});
                check("zero", {31'b0, zero_o}, {31'b0, e.zero});
            end
        end
        if (in_valid_i && in_ready_o) begin
            sb.push_back(cur_exp);
            accepted = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 50 && sb.size() > 0; i++) cycle();
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t         tv [12];
    logic [W-1:0] ba [8];
    logic [W-1:0] bb [8];
    logic         bc [8];
    logic         bs [8];
    logic [W-1:0] cap_s;
    logic [2:0]   cap_f;
    int           idx;
    int           cyc;
    int           lat;
    int           n0;
    int           tries;
    bit           stale;

    initial begin
        rst = 1'b1; in_valid_i = 1'b0; A_i = '0; B_i = '0; Cin_i = 1'b0;
        sub_i = OP_ADD; out_ready_i = 1'b1;
        #2;
        check("rst_out_valid", {31'b0, out_valid_o}, '0);
        check("rst_S",         S_o, '0);
        check("rst_flags",     {29'b0, Cout_o, ovf_o, zero_o}, '0);
        check("rst_in_ready",  {31'b0, in_ready_o}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_in_ready", {31'b0, in_ready_o}, 32'd1);

        // Directed vector table
        tv[0]  = mkv(32'hFFFF_FFFF, 32'd1,        1'b0, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        tv[1]  = mkv(32'd5,         32'd7,        1'b0, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        tv[2]  = mkv(32'h7FFF_FFFF, 32'd1,        1'b0, OP_ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        tv[3]  = mkv(32'hFFFF_FFFF, 32'd0,        1'b1, OP_ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        tv[4]  = mkv(32'd7,         32'd5,        1'b0, OP_SUB, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        tv[5]  = mkv(32'h8000_0000, 32'd1,        1'b0, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        tv[6]  = mkv(32'd5,         32'd5,        1'b0, OP_SUB, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        tv[7]  = mkv(32'h0000_FFFF, 32'd1,        1'b0, OP_ADD, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        tv[8]  = mkv(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, OP_ADD, 32'hACF1_3569, 1'b0, 1'b0, 1'b0);
        tv[9]  = mkv(32'd10,        32'd3,        1'b1, OP_SUB, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        tv[10] = mkv(32'h8000_0000, 32'h8000_0000, 1'b0, OP_ADD, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        tv[11] = mkv(32'd0,         32'd0,        1'b0, OP_ADD, 32'h0000_0000, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            A_i = tv[i].a; B_i = tv[i].b; Cin_i = tv[i].cin; sub_i = tv[i].sub;
            in_valid_i = 1'b1;
            cur_exp.s = tv[i].s; cur_exp.cout = tv[i].cout;
            cur_exp.ovf = tv[i].ovf; cur_exp.zero = tv[i].zero;
            tries = 0;
            do begin
                cycle();
                tries++;
            end while (!accepted && tries < 20);
            check("vec_accept", {31'b0, accepted}, 32'd1);
        end
        drain();

        // Latency of a single beat into an idle pipeline
        drive(32'hDEAD_0001, 32'h0000_FFFF, 1'b0, OP_ADD);
        @(negedge clk);
        sample();
        check("lat_accept", {31'b0, accepted}, 32'd1);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, ST);
        drain();

        // Backpressure: 8 beats, downstream stalls for 5 cycles mid-stream
        for (int i = 0; i < 8; i++) begin
            ba[i] = $urandom; bb[i] = $urandom;
            bc[i] = 1'($urandom_range(0, 1)); bs[i] = 1'($urandom_range(0, 1));
        end
        n0 = n_out; idx = 0; cyc = 0;
        while (idx < 8 && cyc < 60) begin
            out_ready_i = (cyc < 3 || cyc > 7);
            drive(ba[idx], bb[idx], bc[idx], bs[idx]);
            @(negedge clk);
            if (!out_ready_i) begin
                if (cyc == 3) begin
                    cap_s = S_o;
                    cap_f = {Cout_o, ovf_o, zero_o};
                    check("stall_valid", {31'b0, out_valid_o}, 32'd1);
                end else begin
                    check("stall_hold_S",     S_o, cap_s);
                    check("stall_hold_flags", {29'b0, Cout_o, ovf_o, zero_o}, {29'b0, cap_f});
                    check("stall_hold_valid", {31'b0, out_valid_o}, 32'd1);
                end
                check("stall_in_ready", {31'b0, in_ready_o}, '0);
            end
            sample();
            @(posedge clk);
            #1;
            if (accepted) idx++;
            cyc++;
        end
        check("bp_all_sent", idx, 8);
        drain();
        check("bp_count", n_out - n0, 8);

        // Reset with two beats in flight
        idx = 0; tries = 0;
        while (idx < 2 && tries < 20) begin
            drive($urandom, $urandom, 1'b0, OP_ADD);
            cycle();
            if (accepted) idx++;
            tries++;
        end
        in_valid_i = 1'b0;
        check("inflight_valid", {31'b0, out_valid_o}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid",    {31'b0, out_valid_o}, '0);
        check("async_rst_S",        S_o, '0);
        check("async_rst_in_ready", {31'b0, in_ready_o}, 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid_o) stale = 1'b1;
        end
        check("no_stale_after_rst", {31'b0, stale}, '0);
        @(posedge clk);
        #1;

        // Random stream with random valid and ready
        in_valid_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid_i || accepted) begin
                if ($urandom_range(0, 9) < 7) begin
                    case ($urandom_range(0, 3))
                        0:       drive(32'hFFFF_FFFF, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                        1:       drive($urandom, $urandom, 1'($urandom_range(0, 1)), OP_SUB);
                        default: drive($urandom, $urandom, 1'($urandom_range(0, 1)), OP_ADD);
                    endcase
                end else begin
                    in_valid_i = 1'b0;
                end
            end
            out_ready_i = ($urandom_range(0, 9) < 7);
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_adder_cla_pipe
`default_nettype wire

// File: doc/adder_cla_pipe.md
# adder_cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the datapath. It is built from GROUP-bit lookahead groups and splits the word into STAGES segments, registering the inter-segment carry. It carries operands through a valid/ready elastic pipeline with full backpressure and produces sum, carry-out, signed overflow and zero flags. It replaces the fixed 32-bit combinational adder wherever the carry chain limits timing.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of GROUP*STAGES.
- GROUP, 4: bits per lookahead group; legal values 2, 4, 8.
- STAGES, 2: pipeline register stages, which equals segment count; 1..WIDTH/GROUP.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high; clears all state.
- in_valid_i  in  1  operand beat present.
- in_ready_o  out  1  pipeline accepts the beat this cycle.
- A_i  in  WIDTH  operand A.
- B_i  in  WIDTH  operand B.
- Cin_i  in  1  carry-in; used in add mode only.
- sub_i  in  1  0: A+B+Cin_i; 1: A-B, computed as A+~B+1 with Cin_i ignored.
- out_valid_o  out  1  result beat present.
- out_ready_i  in  1  downstream accepts the result.
- S_o  out  WIDTH  sum/difference.
- Cout_o  out  1  carry out of the MSB; in sub mode, 1 = no borrow.
- ovf_o  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero_o  out  1  S_o == 0.

## Operation
- SEG = WIDTH/STAGES bits per segment. Segment k covers bits [(k+1)*SEG-1 : k*SEG] and is evaluated in pipeline stage k.
- Each segment is a chain of SEG/GROUP lookahead groups. Within a group:
  - P = a^b
  - G = a&b
  - carries are computed in parallel
  - group carry-out = GG | (PG & cin)
- Groups within a segment ripple their group carries; segments are separated by registers.
- Accepted beat: B is conditionally inverted (B^{WIDTH{sub_i}}) and the effective carry-in is sub_i ? 1 : Cin_i.
- Stage k registers:
  - valid_k
  - sum bits of segments 0..k
  - carry out of segment k
  - the unconsumed high operand bits of A and B' for segments k+1..STAGES-1
  - carry-into-MSB, only in the stage holding the top segment
  - no mode bit: inversion is already applied
- Last stage drives S_o, Cout_o, ovf_o, zero_o directly from registers. zero_o is a registered compare of the final sum, computed in the last stage.
- Elastic handshake: stage k advances when !valid_k | ready_(k+1), where ready_STAGES = out_ready_i.
  - in_ready_o = !valid_0 | ready_1.
- Beat transfers at input when in_valid_i & in_ready_o; at output when out_valid_o & out_ready_i.
- Stall: while out_valid_o & !out_ready_i, all outputs hold stable and no beat is lost or duplicated.
- No combinational path from in_valid_i or operands to any output. The only combinational path is out_ready_i -> in_ready_o (ready chain).

## Timing
- Latency: a beat accepted at edge n appears with out_valid_o=1 after edge n+STAGES.
- Throughput: one beat per cycle while out_ready_i=1.
- Reset values: out_valid_o=0, S_o=0, Cout_o=0, ovf_o=0, zero_o=0; all internal valids and data registers 0.
- in_ready_o=1 during and immediately after reset.
- Reset asserted mid-operation discards all in-flight beats asynchronously; no output beat is produced for them.
- Simultaneous accept and emit in a full pipeline with out_ready_i=1: both occur in the same cycle and occupancy is unchanged.
- Full pipeline with out_ready_i=0: in_ready_o=0 in the same cycle.
- Wrap-around: unsigned overflow is reported only via Cout_o; S_o is the result modulo 2^WIDTH.
- STAGES=1: a single register level after the full-width chain; behaviour is otherwise identical.

## Structure
- Shared package adder_pkg: default parameter constants (ADD_WIDTH=32, ADD_GROUP=4, ADD_STAGES=2) and an op encoding constant (OP_ADD=1'b0, OP_SUB=1'b1).
- One sub-module, cla_group (parametrised GROUP):
  - inputs: a, b, cin
  - outputs: sum, group propagate, group generate, cout
  - instantiated via generate loops per segment.
- Top-level generate loop builds the stage registers and the ready chain.
- Parameter legality is checked by elaboration-time assertions.

## Test plan
- Defaults, add: A=32'hFFFF_FFFF, B=1, Cin=0 -> after 2 cycles S_o=0, Cout_o=1, zero_o=1, ovf_o=0.
- Sub: A=5, B=7 -> S_o=32'hFFFF_FFFE, Cout_o=0 (borrow), ovf_o=0. Signed overflow: A=32'h7FFF_FFFF, B=1 add -> S_o=32'h8000_0000, ovf_o=1.
- Backpressure: stream 8 random beats, hold out_ready_i=0 for 5 cycles mid-stream -> outputs frozen, in_ready_o=0 once full, all 8 results in order with no loss or duplication.
- Reset mid-stream: assert rst_i with 2 beats in flight -> out_valid_o=0 immediately, no stale beats after release.
- Parameter sweep (WIDTH,GROUP,STAGES) in {(8,2,1), (16,4,2), (32,4,4), (64,8,4)}: 10k random beats with random valid/ready -> matches reference model A±B, latency exactly STAGES.
- Carry across every segment boundary: A=all-ones, B=0, Cin=1 -> S_o=0, Cout_o=1 for each STAGES setting.
